// File: rtl/mips_pkg.sv
// mips_pkg: shared types, constants and lane helpers for the MEM stage.
// Subword support in the stage is enabled with `define MEM_SUBWORD_EN.
package mips_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } mem_state_e;

    function automatic logic [3:0] lane_be(
        input mem_size_e  sz,
        input logic [1:0] off
    );
        logic [3:0] be;
        case (sz)
            BYTE:    be = 4'b0001 << off;
            HALF:    be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'hF;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed lane out of a load word and
// zero- or sign-extends it to XLEN.
module load_align
    import mips_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  mem_size_e       size_i,
    input  logic [1:0]      off_i,
    input  logic            signed_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata_i[{off_i, 3'b000} +: 8];
        h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            BYTE:    data_o = {{24{signed_i & b[7]}}, b};
            HALF:    data_o = {{16{signed_i & h[15]}}, h};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with data-memory handshake and timeout.
// Define MEM_SUBWORD_EN for byte/half accesses; default is word-only.
module mem_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   aluOut,
    input  logic [XLEN-1:0]   writeData,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              memSigned,
    input  logic [1:0]        memSize,
    input  logic              regWrite,
    input  logic [REG_AW-1:0] writeReg,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ack,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              wb_valid,
    output logic              wb_regWrite,
    output logic [REG_AW-1:0] wb_writeReg,
    output logic [XLEN-1:0]   wb_result,
    output logic              bus_err,
    output logic              align_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    mem_state_e        state_q;
    logic [CW-1:0]     cnt_q;
    logic              req_q;
    logic              we_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [3:0]        be_q;
    logic              load_q;
    logic              rw_q;
    mem_size_e         size_q;
    logic [1:0]        off_q;
    logic              sign_q;
    logic              wb_valid_q;
    logic              wb_rw_q;
    logic [REG_AW-1:0] wb_reg_q;
    logic [XLEN-1:0]   wb_res_q;
    logic              bus_err_q;
    logic              align_err_q;

    mem_size_e         sz;
    logic              sgn;
    logic              is_mem;
    logic              misalign;
    logic [3:0]        be_d;
    logic [XLEN-1:0]   wdata_d;
    logic [XLEN-1:0]   ld_data;

`ifdef MEM_SUBWORD_EN
    assign sz  = (memSize == 2'b11) ? WORD
                                    : mem_size_e'(memSize);
    assign sgn = memSigned;
`else
    logic unused_sub;
    assign unused_sub = ^{memSize, memSigned};
    assign sz  = WORD;
    assign sgn = 1'b0;
`endif

    assign is_mem = memRead | memWrite;
    assign be_d   = lane_be(sz, aluOut[1:0]);

    always_comb begin
        misalign = 1'b0;
        wdata_d  = writeData;
        case (sz)
            BYTE: wdata_d = {4{writeData[7:0]}};
            HALF: begin
                misalign = aluOut[0];
                wdata_d  = {2{writeData[15:0]}};
            end
            default: misalign = |aluOut[1:0];
        endcase
    end

    load_align u_load_align (
        .rdata_i  (dmem_rdata),
        .size_i   (size_q),
        .off_i    (off_q),
        .signed_i (sign_q),
        .data_o   (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            load_q      <= 1'b0;
            rw_q        <= 1'b0;
            size_q      <= WORD;
            off_q       <= '0;
            sign_q      <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rw_q     <= 1'b0;
            wb_reg_q    <= '0;
            wb_res_q    <= '0;
            bus_err_q   <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            wb_valid_q  <= 1'b0;
            align_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        wb_reg_q <= writeReg;
                        if (!is_mem) begin
                            wb_valid_q <= 1'b1;
                            wb_rw_q    <= regWrite;
                            wb_res_q   <= aluOut;
                        end else if (misalign) begin
                            wb_valid_q  <= 1'b1;
                            wb_rw_q     <= 1'b0;
                            wb_res_q    <= aluOut;
                            align_err_q <= 1'b1;
                        end else begin
                            state_q <= ACCESS;
                            cnt_q   <= '0;
                            req_q   <= 1'b1;
                            we_q    <= memWrite;
                            addr_q  <= {aluOut[31:2], 2'b00};
                            wdata_q <= wdata_d;
                            be_q    <= be_d;
                            load_q  <= ~memWrite;
                            rw_q    <= regWrite;
                            size_q  <= sz;
                            off_q   <= aluOut[1:0];
                            sign_q  <= sgn;
                        end
                    end
                end
                ACCESS: begin
                    // ack takes priority over a coincident timeout
                    if (dmem_ack) begin
                        state_q    <= RESP;
                        req_q      <= 1'b0;
                        wb_valid_q <= 1'b1;
                        wb_rw_q    <= load_q & rw_q;
                        if (load_q) begin
                            wb_res_q <= ld_data;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_q    <= RESP;
                        req_q      <= 1'b0;
                        bus_err_q  <= 1'b1;
                        wb_valid_q <= 1'b1;
                        wb_rw_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign dmem_be     = be_q;
    assign wb_valid    = wb_valid_q;
    assign wb_regWrite = wb_rw_q;
    assign wb_writeReg = wb_reg_q;
    assign wb_result   = wb_res_q;
    assign bus_err     = bus_err_q;
    assign align_err   = align_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with a writeback scoreboard.
// Subword cases run only when MEM_SUBWORD_EN is defined.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] aluOut;
    logic [31:0] writeData;
    logic        memRead;
    logic        memWrite;
    logic        memSigned;
    logic [1:0]  memSize;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_regWrite;
    logic [4:0]  wb_writeReg;
    logic [31:0] wb_result;
    logic        bus_err;
    logic        align_err;

    int total = 0;
    int bad   = 0;
    int wb_cnt = 0;

    typedef struct packed {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] res;
    } wb_t;

    wb_t sbq[$];

    mem_stage #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .aluOut      (aluOut),
        .writeData   (writeData),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .memSigned   (memSigned),
        .memSize     (memSize),
        .regWrite    (regWrite),
        .writeReg    (writeReg),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_be     (dmem_be),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .wb_valid    (wb_valid),
        .wb_regWrite (wb_regWrite),
        .wb_writeReg (wb_writeReg),
        .wb_result   (wb_result),
        .bus_err     (bus_err),
        .align_err   (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            wb_t e;
            wb_cnt++;
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $error("FAIL wb_extra observed=%h expected=none",
                       wb_result);
            end else begin
                e = sbq.pop_front();
                chk("wb_regWrite", 32'(wb_regWrite), 32'(e.rw));
                chk("wb_writeReg", 32'(wb_writeReg), 32'(e.rd));
                if (e.rw) chk("wb_result", wb_result, e.res);
            end
        end
    end

    task automatic drive(input logic [31:0] alu,
                         input logic [31:0] wd,
                         input logic rd, input logic wr,
                         input logic sg, input logic [1:0] sz,
                         input logic rw, input logic [4:0] rg);
        in_valid  = 1'b1;
        aluOut    = alu;
        writeData = wd;
        memRead   = rd;
        memWrite  = wr;
        memSigned = sg;
        memSize   = sz;
        regWrite  = rw;
        writeReg  = rg;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"},    32'(dmem_req),    32'd0);
        chk({tag, "_we"},     32'(dmem_we),     32'd0);
        chk({tag, "_be"},     32'(dmem_be),     32'd0);
        chk({tag, "_addr"},   dmem_addr,        32'd0);
        chk({tag, "_wdata"},  dmem_wdata,       32'd0);
        chk({tag, "_wbv"},    32'(wb_valid),    32'd0);
        chk({tag, "_wbrw"},   32'(wb_regWrite), 32'd0);
        chk({tag, "_wbreg"},  32'(wb_writeReg), 32'd0);
        chk({tag, "_wbres"},  wb_result,        32'd0);
        chk({tag, "_buserr"}, 32'(bus_err),     32'd0);
        chk({tag, "_alerr"},  32'(align_err),   32'd0);
        chk({tag, "_ready"},  32'(in_ready),    32'd1);
    endtask

    // Issues one aligned memory op and services the bus; ack_at is the
    // request cycle (1-based) in which ack is driven, 0 for never.
    task automatic mem_op(input string tag,
                          input logic [31:0] alu,
                          input logic [31:0] wd,
                          input logic rd, input logic wr,
                          input logic sg, input logic [1:0] sz,
                          input logic rw, input logic [4:0] rg,
                          input int ack_at,
                          input logic [31:0] rdata,
                          input logic [31:0] e_addr,
                          input logic [3:0] e_be,
                          input logic e_we,
                          input logic [31:0] e_wdata,
                          input logic e_rw,
                          input logic [31:0] e_res,
                          input int e_cycles);
        int  n;
        bit  done;
        drive(alu, wd, rd, wr, sg, sz, rw, rg);
        sbq.push_back({e_rw, rg, e_res});
        @(negedge clk);
        idle_in();
        n = 0;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (dmem_req) begin
                n++;
                if (n == 1) begin
                    chk({tag, "_addr"},  dmem_addr,    e_addr);
                    chk({tag, "_be"},    32'(dmem_be), 32'(e_be));
                    chk({tag, "_we"},    32'(dmem_we), 32'(e_we));
                    chk({tag, "_wdata"}, dmem_wdata,   e_wdata);
                end
                chk({tag, "_busy"}, 32'(in_ready), 32'd0);
                if (n == ack_at) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                end
                @(negedge clk);
                dmem_ack   = 1'b0;
                dmem_rdata = 32'h0BADF00D;
            end else begin
                done = 1;
            end
        end
        chk({tag, "_reqcyc"}, 32'(n), 32'(e_cycles));
        chk({tag, "_wbpulse"}, 32'(wb_valid), 32'd1);
        chk({tag, "_resp"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        chk({tag, "_wbdone"}, 32'(wb_valid), 32'd0);
        chk({tag, "_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic mis_op(input string tag,
                          input logic [31:0] alu,
                          input logic rd, input logic wr,
                          input logic [1:0] sz,
                          input logic [4:0] rg);
        drive(alu, 32'h55AA55AA, rd, wr, 1'b0, sz, 1'b1, rg);
        sbq.push_back({1'b0, rg, 32'd0});
        @(negedge clk);
        idle_in();
        chk({tag, "_alerr"}, 32'(align_err), 32'd1);
        chk({tag, "_wbv"},   32'(wb_valid),  32'd1);
        chk({tag, "_noreq"}, 32'(dmem_req),  32'd0);
        chk({tag, "_ready"}, 32'(in_ready),  32'd1);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(align_err), 32'd0);
        chk({tag, "_noreq2"}, 32'(dmem_req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        rst_n      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0BADF00D;
        drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 5'd0);
        idle_in();
        #2;
        chk_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ALU passthrough, back-to-back
        drive(32'd42, 32'd0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 5'd3);
        sbq.push_back({1'b1, 5'd3, 32'd42});
        @(negedge clk);
        chk("alu_wbv", 32'(wb_valid), 32'd1);
        chk("alu_noreq", 32'(dmem_req), 32'd0);
        chk("alu_ready", 32'(in_ready), 32'd1);
        drive(32'd7, 32'd0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 5'd4);
        sbq.push_back({1'b1, 5'd4, 32'd7});
        @(negedge clk);
        idle_in();
        chk("alu2_wbv", 32'(wb_valid), 32'd1);
        chk("alu2_noreq", 32'(dmem_req), 32'd0);
        @(negedge clk);
        chk("alu_idle_wbv", 32'(wb_valid), 32'd0);

        mem_op("ldw", 32'h100, 32'h11223344, 1, 0, 0, 2'b10, 1,
               5'd5, 3, 32'hDEADBEEF, 32'h100, 4'hF, 0,
               32'h11223344, 1, 32'hDEADBEEF, 3);

        mem_op("stw", 32'h204, 32'hCAFEF00D, 0, 1, 0, 2'b10, 1,
               5'd6, 1, 32'h0, 32'h204, 4'hF, 1,
               32'hCAFEF00D, 0, 32'h0, 1);

        mem_op("rdwr", 32'h308, 32'h01020304, 1, 1, 0, 2'b10, 1,
               5'd7, 2, 32'hFFFFFFFF, 32'h308, 4'hF, 1,
               32'h01020304, 0, 32'h0, 2);

        mem_op("ackwin", 32'h40C, 32'h0, 1, 0, 0, 2'b10, 1,
               5'd8, 16, 32'h12345678, 32'h40C, 4'hF, 0,
               32'h0, 1, 32'h12345678, 16);
        chk("ackwin_buserr", 32'(bus_err), 32'd0);

        mem_op("ldnorw", 32'h10, 32'h0, 1, 0, 0, 2'b10, 0,
               5'd9, 1, 32'hA5A5A5A5, 32'h10, 4'hF, 0,
               32'h0, 0, 32'h0, 1);

        mis_op("misw", 32'h102, 1, 0, 2'b10, 5'd10);

`ifdef MEM_SUBWORD_EN
        mem_op("lbs", 32'h103, 32'hAB, 1, 0, 1, 2'b00, 1,
               5'd11, 1, 32'h80000000, 32'h100, 4'b1000, 0,
               32'hABABABAB, 1, 32'hFFFFFF80, 1);
        mem_op("lhu", 32'h102, 32'h1234, 1, 0, 0, 2'b01, 1,
               5'd12, 2, 32'h80010000, 32'h100, 4'b1100, 0,
               32'h12341234, 1, 32'h00008001, 2);
        mis_op("mish", 32'h101, 1, 0, 2'b01, 5'd13);
`else
        mis_op("misb", 32'h103, 1, 0, 2'b00, 5'd11);
        mem_op("lbword", 32'h100, 32'h000000AB, 1, 0, 1, 2'b00, 1,
               5'd12, 1, 32'h80000080, 32'h100, 4'hF, 0,
               32'h000000AB, 1, 32'h80000080, 1);
`endif

        // ack while idle must not start anything
        snap = wb_cnt;
        dmem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("idleack_wb", 32'(wb_cnt), 32'(snap));
        chk("idleack_req", 32'(dmem_req), 32'd0);
        chk("idleack_ready", 32'(in_ready), 32'd1);

        mem_op("sttmo", 32'h500, 32'h77, 0, 1, 0, 2'b10, 1,
               5'd14, 0, 32'h0, 32'h500, 4'hF, 1,
               32'h77, 0, 32'h0, 16);
        chk("tmo_buserr", 32'(bus_err), 32'd1);

        drive(32'd99, 32'd0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 5'd15);
        sbq.push_back({1'b1, 5'd15, 32'd99});
        @(negedge clk);
        idle_in();
        @(negedge clk);
        chk("sticky_buserr", 32'(bus_err), 32'd1);

        // reset during the second access cycle
        drive(32'h600, 32'd0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 5'd16);
        @(negedge clk);
        idle_in();
        chk("rst_req1", 32'(dmem_req), 32'd1);
        @(negedge clk);
        chk("rst_req2", 32'(dmem_req), 32'd1);
        snap = wb_cnt;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("midrst_nowb", 32'(wb_cnt), 32'(snap));
        chk("midrst_noreq", 32'(dmem_req), 32'd0);
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
